// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to enable the even-parity bit between data and stop.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    par_bad_d = ^{shift_q, rx_s_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        // Framing error takes precedence over parity.
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        data_d  = shift_q;
`endif
                    end
                end
            end
            BREAK: begin
                timer_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL provide parameter CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL provide parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL provide localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), and SHALL require CLKS_PER_BIT >= 4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-007 The block SHALL have port data_out, output, 8 bits: last correctly received byte.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch (see Configuration).
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE -> START when rx_s is 0; clear the bit-timer.
REQ-016 START: at timer = CLKS_PER_BIT/2 - 1, if rx_s is 0 go to DATA (timer cleared), else treat as glitch and return to IDLE with no output pulse.
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles, shift into bit position 0..7 in order; after bit 7 go to PARITY if enabled, else STOP.
REQ-018 PARITY: sample after CLKS_PER_BIT cycles, then go to STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; if 1 and no parity error, load data_out, pulse valid, go to IDLE.
REQ-020 STOP sample 1 with parity error: pulse parity_err, leave data_out unchanged, go to IDLE.
REQ-021 STOP sample 0: pulse frame_err, leave data_out unchanged, go to BREAK; parity_err SHALL NOT also pulse.
REQ-022 BREAK: remain until rx_s is 1, then go to IDLE; no new start detection while in BREAK.
REQ-023 valid, frame_err and parity_err SHALL be registered, at most one asserted per frame, each exactly one cycle wide, asserted the cycle after the stop sample.
REQ-024 Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint SHALL be received without loss.
REQ-025 data_out SHALL hold its value between valid pulses.
REQ-026 The bit-timer SHALL be sized to $clog2(CLKS_PER_BIT) bits and SHALL wrap to 0 on every sample.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, timer 0, shift register 0, synchronizer flops 1, data_out 8'h00, and valid, frame_err, parity_err, busy all 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release the block SHALL resume in IDLE and wait for the next falling edge.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL be used and even parity SHALL be checked (XOR of 8 data bits and the parity bit must be 0).
REQ-030 Without UART_RX_PARITY_EN, the PARITY state SHALL be skipped (DATA -> STOP) and parity_err SHALL be tied to 0; all ports SHALL remain present.

Verification (bench parameters CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10)
REQ-031 Send frame 8'hA5 with stop=1 -> one valid pulse, data_out=8'hA5, frame_err=0, parity_err=0.
REQ-032 Send 8'h3C then 8'hC3 back-to-back -> two valid pulses with data_out 8'h3C then 8'hC3.
REQ-033 Send 8'h55 with stop=0, hold rx low for 30 clocks, then send 8'h0F -> one frame_err pulse, data_out stays at its prior value, then valid with 8'h0F.
REQ-034 Drive a 3-clock low glitch on idle rx -> no pulses, busy returns to 0 within 6 clocks.
REQ-035 Assert rst_n low during data bit 4 of 8'hFF, release, then send 8'h81 -> no pulse for the aborted frame, data_out=8'h00, then valid with 8'h81.
REQ-036 With UART_RX_PARITY_EN: send 8'h07 with parity 1 -> valid; send 8'h07 with parity 0 -> parity_err pulse and data_out unchanged.
